// File: rtl/conv1d_pkg.sv
// Shared constants, command codes, response codes and FSM state type for the
// 1-D convolution scheduler.
package conv1d_pkg;

    localparam int KERNEL_LENGTH = 8;
    localparam int MAX_LEN       = 1024;
    localparam int MAX_CH        = 128;
    localparam int LANES         = 4;
    localparam int PADDING       = 4;

    // Padded input row index width: out_idx + tap reaches MAX_LEN + 2*PADDING - 2
    localparam int ROW_W = $clog2(MAX_LEN + 2 * PADDING);

    localparam logic [6:0] CMD_START  = 7'd4;
    localparam logic [6:0] CMD_STATUS = 7'd9;
    localparam logic [6:0] CMD_ABORT  = 7'd10;

    localparam logic [31:0] RSP_OK       = 32'h0000_0000;
    localparam logic [31:0] ERR_BAD_ARGS = 32'hFFFF_FFFE;
    localparam logic [31:0] ERR_BUSY     = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/conv1d_rsp_slot.sv
// Single-entry response register with a valid/ready handshake. A new word is
// only loaded while the slot is empty, so the word is stable until taken.
module conv1d_rsp_slot (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        rsp_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data
);

    // Capture a response on load, release it once the consumer takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_data  <= load_data;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/conv1d_scheduler.sv
// Command-driven scheduler that walks output positions, kernel taps and
// channel groups of a 1-D convolution and strobes the MAC datapath.
module conv1d_scheduler
    import conv1d_pkg::*;
#(
    parameter int PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [6:0]       funct7,
    input  logic [31:0]      inp0,
    input  logic [31:0]      inp1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             mac_clear,
    output logic             mac_en,
    output logic [ROW_W-1:0] in_row,
    output logic [2:0]       ker_tap,
    output logic [4:0]       ch_word,
    output logic             out_wr_en,
    output logic [9:0]       out_idx,
    output logic             busy
);

    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);
    localparam logic [2:0] TAP_LAST = 3'(KERNEL_LENGTH - 1);

    state_t state_q, state_d;

    logic [9:0]         len_m1_q;
    logic [4:0]         w_m1_q;
    logic [2:0]         tap_q;
    logic [4:0]         ch_q;
    logic [DRAIN_W-1:0] drain_q;
    logic [9:0]         idx_q;
    logic               done_q;

    logic        accept;
    logic        is_start;
    logic        is_abort;
    logic        idle;
    logic        args_ok;
    logic        start_go;
    logic [31:0] rsp_next;

    assign cmd_ready = ~rsp_valid;
    assign accept    = cmd_valid & ~rsp_valid;
    assign is_start  = accept & (funct7 == CMD_START);
    assign is_abort  = accept & (funct7 == CMD_ABORT);
    assign idle      = (state_q == ST_IDLE);
    assign args_ok   = (inp0 != 32'd0) && (inp0 <= 32'(MAX_LEN)) &&
                       (inp1 >= 32'(LANES)) && (inp1 <= 32'(MAX_CH)) &&
                       (inp1[1:0] == 2'b00);
    assign start_go  = is_start & idle & args_ok;

    // Build the response word for whichever command is being accepted
    always_comb begin
        rsp_next = RSP_OK;
        case (funct7)
            CMD_START: begin
                if (!idle)
                    rsp_next = ERR_BUSY;
                else if (!args_ok)
                    rsp_next = ERR_BAD_ARGS;
            end
            CMD_STATUS: rsp_next = {busy, done_q, 20'b0, idx_q};
            default:    rsp_next = RSP_OK;
        endcase
    end

    conv1d_rsp_slot u_rsp_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_data (rsp_next),
        .rsp_ready (rsp_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and datapath strobes; an accepted ABORT overrides everything
    always_comb begin
        state_d   = state_q;
        mac_clear = 1'b0;
        mac_en    = 1'b0;
        out_wr_en = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_go)
                    state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                mac_clear = 1'b1;
                busy      = 1'b1;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                mac_en = 1'b1;
                busy   = 1'b1;
                if (tap_q == TAP_LAST && ch_q == w_m1_q)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (drain_q == DRAIN_LAST)
                    state_d = ST_WRITE;
            end
            ST_WRITE: begin
                busy      = 1'b1;
                out_wr_en = ~is_abort;
                state_d   = (idx_q == len_m1_q) ? ST_DONE : ST_CLEAR;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (is_abort)
            state_d = ST_IDLE;
    end

    // Job parameters, loop counters and the sticky done flag
    always_ff @(posedge clk) begin
        if (reset) begin
            len_m1_q <= 10'd0;
            w_m1_q   <= 5'd0;
            tap_q    <= 3'd0;
            ch_q     <= 5'd0;
            drain_q  <= '0;
            idx_q    <= 10'd0;
            done_q   <= 1'b0;
        end else if (is_abort) begin
            done_q <= 1'b0;
        end else begin
            if (start_go) begin
                len_m1_q <= 10'(inp0 - 32'd1);
                w_m1_q   <= 5'(inp1[7:2] - 6'd1);
                idx_q    <= 10'd0;
                done_q   <= 1'b0;
            end
            case (state_q)
                ST_CLEAR: begin
                    tap_q   <= 3'd0;
                    ch_q    <= 5'd0;
                    drain_q <= '0;
                end
                ST_RUN: begin
                    drain_q <= '0;
                    if (ch_q == w_m1_q) begin
                        ch_q  <= 5'd0;
                        tap_q <= tap_q + 3'd1;
                    end else begin
                        ch_q <= ch_q + 5'd1;
                    end
                end
                ST_DRAIN: drain_q <= drain_q + 1'b1;
                ST_WRITE: begin
                    if (idx_q != len_m1_q)
                        idx_q <= idx_q + 10'd1;
                end
                ST_DONE: done_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // Address outputs follow the counters directly
    always_comb begin
        in_row  = ROW_W'(idx_q) + ROW_W'(tap_q);
        ker_tap = tap_q;
        ch_word = ch_q;
        out_idx = idx_q;
    end

endmodule
